// File: rtl/llr_user_scheduler.sv
// Per-user job sequencer for the slow-PHY-to-LLR converter.
// Optional stats outputs under `define LLR_SCHED_STATS_EN.
module llr_user_scheduler #(
  parameter int QDEPTH     = 4,
  parameter int UID_W      = 8,
  parameter int TIMEOUT    = 4096,
  parameter int FSMRST_CYC = 2
) (
  input  logic             i_core_clk,
  input  logic             i_rx_rstn,
  input  logic             i_desc_valid,
  output logic             o_desc_ready,
  input  logic [15:0]      i_desc_re_amounts,
  input  logic [15:0]      i_desc_iq_noise_rate,
  input  logic [UID_W-1:0] i_desc_uid,
  output logic             o_conv_fsm_rstn,
  output logic [15:0]      o_conv_re_amounts,
  output logic [15:0]      o_conv_iq_noise_rate,
  input  logic             i_conv_strobe,
  output logic             o_busy,
  output logic             o_user_done,
  output logic             o_user_err,
`ifdef LLR_SCHED_STATS_EN
  output logic [31:0]      o_stat_users,
  output logic [15:0]      o_stat_errs,
  output logic [31:0]      o_stat_stall_cyc,
`endif
  output logic [UID_W-1:0] o_user_uid
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CW = (FSMRST_CYC > 1) ? $clog2(FSMRST_CYC) : 1;

  localparam logic [AW:0]   QFULL    = (AW+1)'(QDEPTH);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] RC_LAST  = CW'(FSMRST_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CFGRST,
    S_RUN,
    S_DONE
  } state_t;

  logic [15:0]      re_mem   [QDEPTH];
  logic [15:0]      rate_mem [QDEPTH];
  logic [UID_W-1:0] uid_mem  [QDEPTH];

  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          full, empty, push, pop;

  logic [15:0]      head_re, head_rate, head_exp;
  logic [UID_W-1:0] head_uid;

  state_t           state_q, state_d;
  logic [CW-1:0]    rcyc_q, rcyc_d;
  logic [15:0]      stb_q, stb_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             err_q, err_d;
  logic [15:0]      exp_q;
  logic [15:0]      re_q, rate_q;
  logic [UID_W-1:0] uid_q;
  logic             rstn_q;

  assign full  = (cnt_q == QFULL);
  assign empty = (cnt_q == '0);
  assign pop   = (state_q == S_IDLE) & ~empty;

  assign o_desc_ready = ~full | pop;
  assign push         = i_desc_valid & o_desc_ready;

  assign head_re   = re_mem[rp_q];
  assign head_rate = rate_mem[rp_q];
  assign head_uid  = uid_mem[rp_q];
  // ceil(re/2) without a 17-bit intermediate
  assign head_exp  = {1'b0, head_re[15:1]} + {15'd0, head_re[0]};

  always_ff @(posedge i_core_clk) begin
    if (push) begin
      re_mem[wp_q]   <= i_desc_re_amounts;
      rate_mem[wp_q] <= i_desc_iq_noise_rate;
      uid_mem[wp_q]  <= i_desc_uid;
    end
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      unique case (1'b1)
        push & ~pop: cnt_q <= cnt_q + (AW+1)'(1);
        pop & ~push: cnt_q <= cnt_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    rcyc_d  = rcyc_q;
    stb_d   = stb_q;
    tmr_d   = tmr_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        rcyc_d = '0;
        if (pop) state_d = S_CFGRST;
      end
      S_CFGRST: begin
        if (rcyc_q == RC_LAST) begin
          rcyc_d  = '0;
          state_d = (exp_q == 16'd0) ? S_DONE : S_RUN;
        end else begin
          rcyc_d = rcyc_q + CW'(1);
        end
      end
      S_RUN: begin
        if (i_conv_strobe) begin
          stb_d = stb_q + 16'd1;
          tmr_d = '0;
          if (stb_d == exp_q) state_d = S_DONE;
        end else begin
          tmr_d = tmr_q + TW'(1);
          if (tmr_d == TMR_LAST) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE: begin
        stb_d   = '0;
        tmr_d   = '0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state_q <= S_IDLE;
      rcyc_q  <= '0;
      stb_q   <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
      exp_q   <= '0;
      re_q    <= '0;
      rate_q  <= '0;
      uid_q   <= '0;
      rstn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rcyc_q  <= rcyc_d;
      stb_q   <= stb_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      rstn_q  <= (state_d != S_CFGRST);
      if (pop) begin
        exp_q  <= head_exp;
        re_q   <= head_re;
        rate_q <= head_rate;
        uid_q  <= head_uid;
      end
    end
  end

  assign o_conv_fsm_rstn      = rstn_q;
  assign o_conv_re_amounts    = re_q;
  assign o_conv_iq_noise_rate = rate_q;
  assign o_busy      = (state_q == S_CFGRST) | (state_q == S_RUN);
  assign o_user_done = (state_q == S_DONE);
  assign o_user_err  = o_user_done & err_q;
  assign o_user_uid  = o_user_done ? uid_q : '0;

`ifdef LLR_SCHED_STATS_EN
  logic [31:0] users_q, stall_q;
  logic [15:0] errs_q;

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      users_q <= '0;
      errs_q  <= '0;
      stall_q <= '0;
    end else begin
      if (o_user_done) users_q <= users_q + 32'd1;
      if (o_user_err)  errs_q  <= errs_q + 16'd1;
      if ((state_q == S_RUN) & ~i_conv_strobe)
        stall_q <= stall_q + 32'd1;
    end
  end

  assign o_stat_users     = users_q;
  assign o_stat_errs      = errs_q;
  assign o_stat_stall_cyc = stall_q;
`endif

endmodule

// File: tb/tb_llr_user_scheduler.sv
// Directed bench for llr_user_scheduler: handshake, job
// sequencing, timeout, zero-RE users and mid-job reset.
module tb_llr_user_scheduler;

  localparam int UW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_desc_valid;
  logic          o_desc_ready;
  logic [15:0]   i_desc_re_amounts;
  logic [15:0]   i_desc_iq_noise_rate;
  logic [UW-1:0] i_desc_uid;
  logic          o_conv_fsm_rstn;
  logic [15:0]   o_conv_re_amounts;
  logic [15:0]   o_conv_iq_noise_rate;
  logic          i_conv_strobe;
  logic          o_busy;
  logic          o_user_done;
  logic          o_user_err;
  logic [UW-1:0] o_user_uid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  llr_user_scheduler #(
    .QDEPTH    (4),
    .UID_W     (UW),
    .TIMEOUT   (4096),
    .FSMRST_CYC(2)
  ) dut (
    .i_core_clk          (clk),
    .i_rx_rstn           (rstn),
    .i_desc_valid        (i_desc_valid),
    .o_desc_ready        (o_desc_ready),
    .i_desc_re_amounts   (i_desc_re_amounts),
    .i_desc_iq_noise_rate(i_desc_iq_noise_rate),
    .i_desc_uid          (i_desc_uid),
    .o_conv_fsm_rstn     (o_conv_fsm_rstn),
    .o_conv_re_amounts   (o_conv_re_amounts),
    .o_conv_iq_noise_rate(o_conv_iq_noise_rate),
    .i_conv_strobe       (i_conv_strobe),
    .o_busy              (o_busy),
    .o_user_done         (o_user_done),
    .o_user_err          (o_user_err),
    .o_user_uid          (o_user_uid)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] re,
                      input logic [15:0] rate,
                      input logic [UW-1:0] uid);
    bit ok;
    ok = 1'b0;
    i_desc_re_amounts    = re;
    i_desc_iq_noise_rate = rate;
    i_desc_uid           = uid;
    i_desc_valid         = 1'b1;
    for (int k = 0; k < 10000 && !ok; k++) begin
      ok = o_desc_ready;
      @(negedge clk);
    end
    i_desc_valid = 1'b0;
    check("push_ok", 32'(ok), 1);
  endtask

  task automatic wait_run(output int lows, output bit ok);
    lows = 0;
    ok   = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (o_busy && o_conv_fsm_rstn) ok = 1'b1;
      else begin
        if (!o_conv_fsm_rstn) lows++;
        @(negedge clk);
      end
    end
  endtask

  task automatic serve(input int nstb, input int uid,
                       input int err, input int lat,
                       input string tag, output int lows);
    bit ok;
    bit early;
    int d;
    wait_run(lows, ok);
    check({tag, "_run"}, 32'(ok), 1);
    early = 1'b0;
    for (int i = 0; i < nstb; i++) begin
      if (o_user_done) early = 1'b1;
      i_conv_strobe = 1'b1;
      @(negedge clk);
    end
    i_conv_strobe = 1'b0;
    d = 1;
    while (!o_user_done && d < 5000) begin
      @(negedge clk);
      d++;
    end
    check({tag, "_early"}, 32'(early), 0);
    check({tag, "_lat"}, d, lat);
    check({tag, "_uid"}, 32'(o_user_uid), uid);
    check({tag, "_err"}, 32'(o_user_err), err);
  endtask

  initial begin
    int  lows;
    int  d;
    bit  ok;
    rstn                 = 1'b0;
    i_desc_valid         = 1'b0;
    i_desc_re_amounts    = '0;
    i_desc_iq_noise_rate = '0;
    i_desc_uid           = '0;
    i_conv_strobe        = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(o_desc_ready), 1);
    check("rst_convrstn", 32'(o_conv_fsm_rstn), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_user_done), 0);
    check("rst_err", 32'(o_user_err), 0);
    check("rst_uid", 32'(o_user_uid), 0);
    check("rst_re", 32'(o_conv_re_amounts), 0);
    check("rst_rate", 32'(o_conv_iq_noise_rate), 0);
    rstn = 1'b1;
    check("rel_convrstn", 32'(o_conv_fsm_rstn), 0);
    @(negedge clk);
    check("idle_convrstn", 32'(o_conv_fsm_rstn), 1);

    // single long user, strobe every cycle
    push(16'd1800, 16'd6, 8'd3);
    check("t1_popbusy", 32'(o_busy), 0);
    serve(900, 3, 0, 1, "t1", lows);
    check("t1_lows", lows, 2);
    check("t1_holdre", 32'(o_conv_re_amounts), 1800);
    check("t1_holdrate", 32'(o_conv_iq_noise_rate), 6);

    // odd RE count, stray strobes between jobs
    push(16'd7, 16'd2, 8'd5);
    push(16'd3, 16'd2, 8'd6);
    serve(4, 5, 0, 1, "t2a", lows);
    check("t2_holdre", 32'(o_conv_re_amounts), 7);
    i_conv_strobe = 1'b1;
    repeat (4) @(negedge clk);
    i_conv_strobe = 1'b0;
    serve(2, 6, 0, 1, "t2b", lows);

    // queue full / push+pop when full / ordering
    push(16'd4, 16'd1, 8'd10);
    push(16'd2, 16'd1, 8'd11);
    push(16'd2, 16'd1, 8'd12);
    push(16'd2, 16'd1, 8'd13);
    push(16'd2, 16'd1, 8'd14);
    check("t3_full", 32'(o_desc_ready), 0);
    serve(2, 10, 0, 1, "t3_10", lows);
    check("t3_donefull", 32'(o_desc_ready), 0);
    @(negedge clk);
    check("t3_popready", 32'(o_desc_ready), 1);
    i_desc_re_amounts    = 16'd2;
    i_desc_iq_noise_rate = 16'd1;
    i_desc_uid           = 8'd15;
    i_desc_valid         = 1'b1;
    @(negedge clk);
    i_desc_valid = 1'b0;
    check("t3_refull", 32'(o_desc_ready), 0);
    serve(1, 11, 0, 1, "t3_11", lows);
    serve(1, 12, 0, 1, "t3_12", lows);
    serve(1, 13, 0, 1, "t3_13", lows);
    serve(1, 14, 0, 1, "t3_14", lows);
    serve(1, 15, 0, 1, "t3_15", lows);

    // strobes stall after 100 of 900
    push(16'd1800, 16'd6, 8'd20);
    push(16'd4, 16'd6, 8'd21);
    serve(100, 20, 1, 4096, "t4", lows);
    serve(2, 21, 0, 1, "t4b", lows);

    // zero REs
    push(16'd0, 16'd1, 8'd9);
    lows = 0;
    d    = 0;
    while (!o_user_done && d < 50) begin
      if (!o_conv_fsm_rstn) lows++;
      @(negedge clk);
      d++;
    end
    check("t5_lat", d, 3);
    check("t5_lows", lows, 2);
    check("t5_uid", 32'(o_user_uid), 9);
    check("t5_err", 32'(o_user_err), 0);

    // reset mid-job
    push(16'd1800, 16'd1, 8'd30);
    wait_run(lows, ok);
    check("t6_run", 32'(ok), 1);
    for (int i = 0; i < 450; i++) begin
      i_conv_strobe = 1'b1;
      @(negedge clk);
    end
    i_conv_strobe = 1'b0;
    rstn = 1'b0;
    #1;
    check("t6_convrstn", 32'(o_conv_fsm_rstn), 0);
    check("t6_busy", 32'(o_busy), 0);
    check("t6_done", 32'(o_user_done), 0);
    check("t6_ready", 32'(o_desc_ready), 1);
    check("t6_re", 32'(o_conv_re_amounts), 0);
    d = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_user_done) d++;
    end
    check("t6_nodone", d, 0);
    rstn = 1'b1;
    check("t6_relhold", 32'(o_conv_fsm_rstn), 0);
    @(negedge clk);
    check("t6_relhigh", 32'(o_conv_fsm_rstn), 1);
    push(16'd10, 16'd2, 8'd31);
    serve(5, 31, 0, 1, "t6b", lows);
    check("t6b_lows", lows, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/llr_user_scheduler.md
Name: llr_user_scheduler

Overview:
- Sequences per-user jobs through the slow-PHY-to-LLR converter (IQ/noise FIFO reader producing RE-pair strobes).
- Accepts user descriptors (RE count, IQ/noise rate, user id) into a small queue.
- For each user in turn: programs the converter, resets its FSM, starts it, counts output strobes, and reports completion or timeout.
- Sits between the upstream user-config source and the converter.

Parameters:
- QDEPTH, 4, descriptor queue depth (power of 2, ≥2)
- UID_W, 8, user id width
- TIMEOUT, 4096, max cycles between converter strobes before abort
- FSMRST_CYC, 2, cycles converter FSM reset is held low between users

Ports:
- i_core_clk  in  1  core clock
- i_rx_rstn  in  1  async active-low reset
- i_desc_valid  in  1  descriptor present
- o_desc_ready  out  1  queue not full
- i_desc_re_amounts  in  16  REs for user
- i_desc_iq_noise_rate  in  16  IQ:noise ratio for user
- i_desc_uid  in  UID_W  user id
- o_conv_fsm_rstn  out  1  converter FSM reset, active low
- o_conv_re_amounts  out  16  config to converter, held stable during the job
- o_conv_iq_noise_rate  out  16  config to converter, held stable during the job
- i_conv_strobe  in  1  converter o_data_strobe (one RE pair)
- o_busy  out  1  job in progress
- o_user_done  out  1  one-cycle completion pulse
- o_user_err  out  1  one-cycle timeout pulse (coincides with o_user_done)
- o_user_uid  out  UID_W  id of finished user, valid with o_user_done

Behaviour:
- Reset values:
  - o_conv_fsm_rstn=0; all other outputs 0, except o_desc_ready=1.
  - Queue emptied, FSM in IDLE.
- Queue: push when i_desc_valid & o_desc_ready. o_desc_ready=0 only when holding QDEPTH entries. Simultaneous push and pop when full is allowed (pop frees the slot in the same cycle; ready stays 1 combinationally from pop).
- Expected strobes: EXP = ceil(re_amounts/2) = (re_amounts+1)>>1, 16-bit. Odd counts end on a half-filled pair.
- FSM:
  - IDLE: o_conv_fsm_rstn=1. When queue non-empty: pop head, latch fields into o_conv_* registers, go to CFGRST.
  - CFGRST: o_conv_fsm_rstn=0 for FSMRST_CYC cycles; o_busy=1. If EXP==0, go to DONE without asserting a strobe count. Otherwise go to RUN.
  - RUN: o_conv_fsm_rstn=1.
    - Each i_conv_strobe increments strobe count and clears the idle timer.
    - Count reaching EXP goes to DONE.
    - Idle timer reaching TIMEOUT-1 goes to DONE with error flag set.
  - DONE (1 cycle):
    - Pulse o_user_done; o_user_err=error flag; o_user_uid=latched id.
    - Clear counters and flag, return to IDLE.
    - Earliest next pop is the following cycle, so back-to-back users are separated by ≥1 IDLE cycle.
- Strobes outside RUN are ignored (no count change).
- A strobe in the same cycle as the timer expiring counts; success takes precedence over timeout.
- o_conv_* hold the last job's values after DONE until the next pop.
- Latency: first pop occurs 1 cycle after a push into an empty idle queue; o_user_done occurs 1 cycle after the final strobe.
- Asynchronous reset mid-job:
  - Drop everything immediately.
  - No done pulse.
  - Converter is held in FSM reset (o_conv_fsm_rstn=0) until i_rx_rstn deasserts, then goes high the next cycle in IDLE.
- Counters saturate-free: strobe count is 16-bit, timer width is clog2(TIMEOUT).

Optional Feature:
- Macro: LLR_SCHED_STATS_EN.
- When defined, adds three outputs, each cleared only by reset:
  - o_stat_users: 32-bit, jobs finished.
  - o_stat_errs: 16-bit, timeouts.
  - o_stat_stall_cyc: 32-bit, RUN cycles without a strobe.
  - All wrap modulo 2^width.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single user, re_amounts=1800, rate=6, uid=3, strobe every cycle → o_conv_fsm_rstn low 2 cycles, 900 strobes, o_user_done with uid=3, err=0, 1 cycle after strobe 900.
- re_amounts=7 → done after exactly 4 strobes; a 5th strobe arriving after DONE does not affect the next job's count.
- Push 5 descriptors back-to-back with QDEPTH=4 while busy → o_desc_ready drops after the 4th queued entry, reasserts on pop; all 5 uids complete in push order.
- Strobes stop after 100 of 900, TIMEOUT=4096 → o_user_done=o_user_err=1 exactly 4096 cycles after strobe 100; next queued user proceeds normally.
- re_amounts=0, uid=9 → done pulse with err=0, zero strobes counted, fsm reset pulse still issued.
- Assert i_rx_rstn=0 at strobe 450 of 900 → no done pulse, outputs at reset values; after release, new descriptor runs to full completion.
